playlist_mcu: RTL and testbench

Parametrised music control unit: tracks the current song index and the play/pause state, and drives the note player's restart strobe.
- Supports any playlist length up to 2^SONG_W.
- Adds previous-song navigation and four end-of-song modes.
- Sits between the one-pulsed user buttons and the song reader / note player.
- All buttons and song_done are single-cycle, synchronous pulses from upstream.

---
 rtl/playlist_mcu_if.sv | 24 ++
 rtl/playlist_mcu.sv | 121 ++++++++++++
 tb/tb_playlist_mcu.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/playlist_mcu_if.sv
// Button/event inputs and player-facing outputs of the playlist control unit.
// The master side drives the buttons; the slave side is the control unit.
interface playlist_mcu_if #(
  parameter int SONG_W = 2
);
  logic              play_button;
  logic              next_button;
  logic              prev_button;
  logic              song_done;
  logic [1:0]        end_mode;
  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;

  modport master (
    output play_button, next_button, prev_button, song_done, end_mode,
    input  play, reset_player, song
  );

  modport slave (
    input  play_button, next_button, prev_button, song_done, end_mode,
    output play, reset_player, song
  );
endinterface

// File: rtl/playlist_mcu.sv
// Music control unit: current song index, play/pause state and the note
// player's restart strobe, driven by one-cycle button and song_done pulses.
module playlist_mcu #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2
) (
  input  logic          clk,
  input  logic          reset,
  playlist_mcu_if.slave bus
);

  typedef enum logic {
    PAUSED  = 1'b0,
    PLAYING = 1'b1
  } state_t;

  localparam logic [1:0] MODE_STOP     = 2'b00;
  localparam logic [1:0] MODE_CONTINUE = 2'b01;
  localparam logic [1:0] MODE_REPEAT   = 2'b10;
  localparam logic [1:0] MODE_ONCE     = 2'b11;

  localparam logic [SONG_W-1:0] FIRST_SONG = {SONG_W{1'b0}};
  localparam logic [SONG_W-1:0] LAST_SONG  = SONG_W'(NUM_SONGS - 1);

  if ((NUM_SONGS < 2) || (NUM_SONGS > (1 << SONG_W))) begin : g_bad_params
    $error("playlist_mcu: NUM_SONGS=%0d illegal for SONG_W=%0d", NUM_SONGS, SONG_W);
  end

  state_t            state_r;
  state_t            state_s;
  logic [SONG_W-1:0] song_r;
  logic [SONG_W-1:0] song_s;
  logic [SONG_W-1:0] song_inc_s;
  logic [SONG_W-1:0] song_dec_s;
  logic              reset_player_r;
  logic              reset_player_s;

  // Wrap against the last legal index so non-power-of-2 playlists never overrun.
  always_comb begin
    song_inc_s = song_r + SONG_W'(1);
    song_dec_s = song_r - SONG_W'(1);
    if (song_r == LAST_SONG) begin
      song_inc_s = FIRST_SONG;
    end else begin
      song_inc_s = song_r + SONG_W'(1);
    end
    if (song_r == FIRST_SONG) begin
      song_dec_s = LAST_SONG;
    end else begin
      song_dec_s = song_r - SONG_W'(1);
    end
  end

  // Next state: only the highest-priority pulse (next > prev > done > play) acts.
  always_comb begin
    state_s        = state_r;
    song_s         = song_r;
    reset_player_s = 1'b0;
    if (bus.next_button) begin
      song_s         = song_inc_s;
      reset_player_s = 1'b1;
    end else if (bus.prev_button) begin
      song_s         = song_dec_s;
      reset_player_s = 1'b1;
    end else if (bus.song_done && (state_r == PLAYING)) begin
      reset_player_s = 1'b1;
      case (bus.end_mode)
        MODE_STOP: begin
          song_s  = song_inc_s;
          state_s = PAUSED;
        end
        MODE_CONTINUE: begin
          song_s  = song_inc_s;
          state_s = PLAYING;
        end
        MODE_REPEAT: begin
          song_s  = song_r;
          state_s = PLAYING;
        end
        MODE_ONCE: begin
          song_s = song_inc_s;
          if (song_r == LAST_SONG) begin
            state_s = PAUSED;
          end else begin
            state_s = PLAYING;
          end
        end
        default: begin
          song_s  = song_r;
          state_s = state_r;
        end
      endcase
    end else if (bus.play_button) begin
      if (state_r == PLAYING) begin
        state_s = PAUSED;
      end else begin
        state_s = PLAYING;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, song index and restart strobe registers; reset holds the strobe high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= PAUSED;
      song_r         <= FIRST_SONG;
      reset_player_r <= 1'b1;
    end else begin
      state_r        <= state_s;
      song_r         <= song_s;
      reset_player_r <= reset_player_s;
    end
  end

  assign bus.play         = (state_r == PLAYING);
  assign bus.song         = song_r;
  assign bus.reset_player = reset_player_r;

endmodule

// File: tb/tb_playlist_mcu.sv
// Bench for playlist_mcu: a 4-song and a 3-song instance share stimulus and
// are checked against a modulo-arithmetic playlist model, plus directed vectors.
module tb_playlist_mcu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nb = 1'b0;
  logic       pv = 1'b0;
  logic       dn = 1'b0;
  logic       pb = 1'b0;
  logic [1:0] md = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;

  int m_play[2];
  int m_song[2];
  int m_rp[2];
  int n_songs[2] = '{4, 3};

  typedef struct {
    logic       nb;
    logic       pv;
    logic       dn;
    logic       pb;
    logic [1:0] md;
    int         e_song;
    int         e_play;
    int         e_rp;
  } vec_t;

  vec_t tbl[$];

  playlist_mcu_if #(.SONG_W(2)) ifa ();
  playlist_mcu_if #(.SONG_W(2)) ifb ();

  assign ifa.play_button = pb;
  assign ifa.next_button = nb;
  assign ifa.prev_button = pv;
  assign ifa.song_done   = dn;
  assign ifa.end_mode    = md;
  assign ifb.play_button = pb;
  assign ifb.next_button = nb;
  assign ifb.prev_button = pv;
  assign ifb.song_done   = dn;
  assign ifb.end_mode    = md;

  playlist_mcu #(.NUM_SONGS(4), .SONG_W(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  playlist_mcu #(.NUM_SONGS(3), .SONG_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  function automatic int get_play(int k);
    return (k == 0) ? int'(ifa.play) : int'(ifb.play);
  endfunction

  function automatic int get_song(int k);
    return (k == 0) ? int'(ifa.song) : int'(ifb.song);
  endfunction

  function automatic int get_rp(int k);
    return (k == 0) ? int'(ifa.reset_player) : int'(ifb.reset_player);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dut%0d song", tag, k), get_song(k), m_song[k]);
      chk($sformatf("%s dut%0d play", tag, k), get_play(k), m_play[k]);
      chk($sformatf("%s dut%0d reset_player", tag, k), get_rp(k), m_rp[k]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_play[k] = 0;
      m_song[k] = 0;
      m_rp[k]   = 1;
    end
  endtask

  // Playlist rules expressed with modulo arithmetic on the song number.
  task automatic model_apply(input int k);
    int n;
    n       = n_songs[k];
    m_rp[k] = 0;
    if (nb) begin
      m_song[k] = (m_song[k] + 1) % n;
      m_rp[k]   = 1;
    end else if (pv) begin
      m_song[k] = (m_song[k] + n - 1) % n;
      m_rp[k]   = 1;
    end else if (dn && (m_play[k] == 1)) begin
      m_rp[k] = 1;
      if (md == 2'd0) begin
        m_song[k] = (m_song[k] + 1) % n;
        m_play[k] = 0;
      end else if (md == 2'd1) begin
        m_song[k] = (m_song[k] + 1) % n;
      end else if (md == 2'd3) begin
        if (m_song[k] == n - 1) m_play[k] = 0;
        m_song[k] = (m_song[k] + 1) % n;
      end
    end else if (pb) begin
      m_play[k] = 1 - m_play[k];
    end
  endtask

  task automatic step(input logic n, input logic p, input logic d, input logic b,
                      input logic [1:0] m, input string tag);
    nb = n; pv = p; dn = d; pb = b; md = m;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_apply(k);
    #1;
    nb = 1'b0; pv = 1'b0; dn = 1'b0; pb = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_model("reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "reset_release");
  endtask

  initial begin
    int exp_next[4];
    int exp_prev[3];
    logic r_n, r_p, r_d, r_b;
    logic [1:0] r_m;

    exp_next = '{1, 2, 0, 1};
    exp_prev = '{0, 2, 1};

    //            nb    pv    dn    pb    md     song play rp
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1, 1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2, 1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 1, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 0, 1, 1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 3, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3, 1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 3, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 0, 0, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1, 1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2, 1, 1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1, 1, 0});

    // Power-on reset: strobe stays high until the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("por play", int'(ifa.play), 0);
    chk("por song", int'(ifa.song), 0);
    chk("por reset_player", int'(ifa.reset_player), 1);
    reset = 1'b0;
    #2;
    chk("release reset_player held", int'(ifa.reset_player), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "first_edge");
    chk("first_edge reset_player", int'(ifa.reset_player), 0);

    foreach (tbl[i]) begin
      step(tbl[i].nb, tbl[i].pv, tbl[i].dn, tbl[i].pb, tbl[i].md, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d song", i), int'(ifa.song), tbl[i].e_song);
      chk($sformatf("vec%0d play", i), int'(ifa.play), tbl[i].e_play);
      chk($sformatf("vec%0d reset_player", i), int'(ifa.reset_player), tbl[i].e_rp);
    end

    // Three-song playlist wraps at 2, not at 3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "n3_next");
      chk($sformatf("n3 next%0d song", i), int'(ifb.song), exp_next[i]);
      chk($sformatf("n3 next%0d play", i), int'(ifb.play), 0);
      chk($sformatf("n3 next%0d reset_player", i), int'(ifb.reset_player), 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "n3_prev");
      chk($sformatf("n3 prev%0d song", i), int'(ifb.song), exp_prev[i]);
    end

    // Asynchronous reset between edges while playing song 2.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "async_play");
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "async_next");
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "async_next");
    chk("pre_async song", int'(ifa.song), 2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async play", int'(ifa.play), 0);
    chk("async song", int'(ifa.song), 0);
    chk("async reset_player", int'(ifa.reset_player), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_model("async_hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, "async_release");
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, "async_resume");
    chk("resume play", int'(ifa.play), 1);
    chk("resume song", int'(ifa.song), 0);

    // Random pulses against the model for both playlist lengths.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      r_n = ($urandom_range(0, 7) == 0);
      r_p = ($urandom_range(0, 7) == 0);
      r_d = ($urandom_range(0, 2) == 0);
      r_b = r_d ? 1'b0 : ($urandom_range(0, 3) == 0);
      r_m = 2'($urandom_range(0, 3));
      step(r_n, r_p, r_d, r_b, r_m, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
